port_serializer: RTL and testbench

- Upstream neighbour of port_deserializer in the triple-ported memory.
- Collects requests from three independent client ports, each with a small per-port buffer.
- Merges them onto one serial stream: sout_data/sout_valid plus a 2-bit entry_id naming the source port (1..3, 0 = invalid).
- The shared memory path consumes the stream and port_deserializer routes responses back by the same entry_id.

---
 rtl/port_serializer.sv | 172 +++++++++++++++++
 tb/tb_port_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_serializer.sv
// port_serializer: three buffered client ports merged onto one registered serial stream.
// Define PORT_SERIALIZER_FIXED_PRIO_EN for fixed priority (port1 > port2 > port3) instead of round-robin.

module port_serializer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             nonempty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ready_o = (count_q < CW'(DEPTH)) && !rst;
    assign push         = push_valid_i && push_ready_o;
    assign head_o       = mem_q[rd_ptr_q];
    assign nonempty_o   = (count_q != '0);

    always_comb begin
        wr_ptr_d = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop_i)
            count_d = count_q + 1'b1;
        else if (!push && pop_i)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read while count_q says it is occupied.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

module port_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] port1_data,
    input  logic             port1_valid,
    output logic             port1_ready,
    input  logic [WIDTH-1:0] port2_data,
    input  logic             port2_valid,
    output logic             port2_ready,
    input  logic [WIDTH-1:0] port3_data,
    input  logic             port3_valid,
    output logic             port3_ready,
    output logic [WIDTH-1:0] sout_data,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic [1:0]       entry_id
);
    logic [2:0][WIDTH-1:0] in_data, head;
    logic [2:0]            in_valid, in_ready, nonempty, pop;
    logic [1:0]            gnt_idx;
    logic                  load;

    logic [WIDTH-1:0] sout_data_q, sout_data_d;
    logic             sout_valid_q, sout_valid_d;
    logic [1:0]       entry_id_q, entry_id_d;

    assign in_data  = {port3_data, port2_data, port1_data};
    assign in_valid = {port3_valid, port2_valid, port1_valid};
    assign port1_ready = in_ready[0];
    assign port2_ready = in_ready[1];
    assign port3_ready = in_ready[2];

    for (genvar g = 0; g < 3; g++) begin : g_port
        port_serializer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push_data_i  (in_data[g]),
            .push_valid_i (in_valid[g]),
            .push_ready_o (in_ready[g]),
            .pop_i        (pop[g]),
            .head_o       (head[g]),
            .nonempty_o   (nonempty[g])
        );
    end

`ifdef PORT_SERIALIZER_FIXED_PRIO_EN
    always_comb begin
        gnt_idx = 2'd0;
        for (int k = 2; k >= 0; k--)
            if (nonempty[k]) gnt_idx = 2'(k);
    end
`else
    logic [1:0] last_grant_q, last_grant_d;

    // Scan from the port after last_grant; descending loop so the nearest candidate wins.
    always_comb begin
        int idx;
        gnt_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(last_grant_q) + k) % 3;
            if (nonempty[idx]) gnt_idx = 2'(idx);
        end
    end

    assign last_grant_d = load ? gnt_idx + 2'd1 : last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 2'd3;
        else     last_grant_q <= last_grant_d;
    end
`endif

    assign load = (!sout_valid_q || sout_ready) && (|nonempty);
    assign pop  = load ? (3'b001 << gnt_idx) : 3'b000;

    always_comb begin
        sout_data_d  = sout_data_q;
        sout_valid_d = sout_valid_q;
        entry_id_d   = entry_id_q;
        if (load) begin
            sout_data_d  = head[gnt_idx];
            entry_id_d   = gnt_idx + 2'd1;
            sout_valid_d = 1'b1;
        end else if (sout_valid_q && sout_ready) begin
            sout_data_d  = '0;
            entry_id_d   = 2'd0;
            sout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sout_data_q  <= '0;
            sout_valid_q <= 1'b0;
            entry_id_q   <= 2'd0;
        end else begin
            sout_data_q  <= sout_data_d;
            sout_valid_q <= sout_valid_d;
            entry_id_q   <= entry_id_d;
        end
    end

    assign sout_data  = sout_data_q;
    assign sout_valid = sout_valid_q;
    assign entry_id   = entry_id_q;
endmodule

// File: tb/tb_port_serializer.sv
// Bench for port_serializer: queue-based reference model checked every cycle, plus directed literal checks.

module tb_port_serializer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       vin = '0;
    logic [WIDTH-1:0] din [3];
    logic             sout_ready = 1'b1;
    logic             p1r, p2r, p3r;
    logic [WIDTH-1:0] sout_data;
    logic             sout_valid;
    logic [1:0]       entry_id;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [WIDTH-1:0] mq [3][$];
    logic             mv = 1'b0;
    logic [WIDTH-1:0] md = '0;
    logic [1:0]       mid = '0;
    int               mlg = 3;
    int               mbase, mp, mg;
    logic             mfound;
    logic [2:0]       macc;
    int               n_push = 0;
    int               n_got = 0;
    logic [9:0]       got [$];

    port_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .port1_data  (din[0]),
        .port1_valid (vin[0]),
        .port1_ready (p1r),
        .port2_data  (din[1]),
        .port2_valid (vin[1]),
        .port2_ready (p2r),
        .port3_data  (din[2]),
        .port3_valid (vin[2]),
        .port3_ready (p3r),
        .sout_data   (sout_data),
        .sout_valid  (sout_valid),
        .sout_ready  (sout_ready),
        .entry_id    (entry_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Model: one queue per port, a single output slot, round-robin (or fixed) pick among non-empty queues.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int p = 0; p < 3; p++) mq[p].delete();
            mv = 1'b0; md = '0; mid = '0; mlg = 3;
        end else begin
            for (int p = 0; p < 3; p++) macc[p] = vin[p] && (mq[p].size() < DEPTH);
`ifdef PORT_SERIALIZER_FIXED_PRIO_EN
            mbase = 0;
`else
            mbase = mlg;
`endif
            mfound = 1'b0;
            mg = 0;
            for (int k = 0; k < 3; k++) begin
                mp = (mbase + k) % 3;
                if (!mfound && mq[mp].size() != 0) begin
                    mfound = 1'b1;
                    mg = mp;
                end
            end
            if (mfound && (!mv || sout_ready)) begin
                md  = mq[mg].pop_front();
                mid = 2'(mg + 1);
                mv  = 1'b1;
                mlg = mg + 1;
            end else if (mv && sout_ready) begin
                mv = 1'b0; md = '0; mid = '0;
            end
            for (int p = 0; p < 3; p++)
                if (macc[p]) begin
                    mq[p].push_back(din[p]);
                    n_push++;
                end
        end
    end

    // Compare every cycle and log accepted beats.
    initial forever begin
        @(negedge clk);
        chk("model", {sout_valid, entry_id, sout_data, p3r, p2r, p1r},
            {mv, mid, md, (!rst && mq[2].size() < DEPTH), (!rst && mq[1].size() < DEPTH),
             (!rst && mq[0].size() < DEPTH)});
        if (sout_valid && sout_ready) begin
            got.push_back({entry_id, sout_data});
            n_got++;
        end
    end

    initial begin
        din[0] = '0; din[1] = '0; din[2] = '0;
        @(negedge clk);
        chk("rst_out", {sout_valid, entry_id, sout_data}, 0);
        chk("rst_ready", {p3r, p2r, p1r}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {p3r, p2r, p1r}, 3'b111);

        // single beat on port 2
        step();
        din[1] = 8'hA5; vin = 3'b010;
        step();
        vin = '0;
        @(negedge clk);
        chk("t1_not_yet", sout_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("t1_beat", {sout_valid, entry_id, sout_data}, {1'b1, 2'd2, 8'hA5});
        @(negedge clk);
        chk("t1_idle", {sout_valid, entry_id}, 0);

        // all ports streaming
        do_reset(); got.delete();
        din = '{8'h11, 8'h22, 8'h33}; vin = 3'b111;
        repeat (10) step();
        vin = '0;
        repeat (8) step();
        for (int k = 0; k < 6; k++) begin
`ifdef PORT_SERIALIZER_FIXED_PRIO_EN
            chk($sformatf("t2_seq%0d", k), 32'(got[k]), {22'd0, 2'd1, 8'h11});
`else
            chk($sformatf("t2_seq%0d", k), 32'(got[k]),
                {22'd0, 2'(k % 3 + 1), 8'(8'h11 * (k % 3 + 1))});
`endif
        end

        // stall with port 1 filling up
        do_reset(); got.delete(); sout_ready = 1'b0;
        din[0] = 8'h01; vin = 3'b001; step();
        din[0] = 8'h02; step();
        din[0] = 8'h03; step();
        vin = '0;
        @(negedge clk);
        chk("t3_full", p1r, 0);
        chk("t3_hold", {sout_valid, entry_id, sout_data}, {1'b1, 2'd1, 8'h01});
        step(); step();
        @(negedge clk);
        chk("t3_hold2", {sout_valid, entry_id, sout_data}, {1'b1, 2'd1, 8'h01});
        step(); sout_ready = 1'b1;
        @(negedge clk);
        chk("t3_still_full", p1r, 0);
        @(negedge clk);
        chk("t3_ready_back", p1r, 1);
        repeat (4) step();
        chk("t3_count", got.size(), 3);
        chk("t3_b0", 32'(got[0]), {22'd0, 2'd1, 8'h01});
        chk("t3_b1", 32'(got[1]), {22'd0, 2'd1, 8'h02});
        chk("t3_b2", 32'(got[2]), {22'd0, 2'd1, 8'h03});

        // push and pop on port 3 in the same cycle
        do_reset(); got.delete(); sout_ready = 1'b1;
        din[2] = 8'h7E; vin = 3'b100; step();
        din[2] = 8'h7F; step();
        vin = '0;
        @(negedge clk);
        chk("t4_first", {sout_valid, entry_id, sout_data}, {1'b1, 2'd3, 8'h7E});
        chk("t4_ready", p3r, 1);
        @(negedge clk);
        chk("t4_second", {sout_valid, entry_id, sout_data}, {1'b1, 2'd3, 8'h7F});
        @(negedge clk);
        chk("t4_empty", sout_valid, 0);

        // reset while every buffer is full and the output is stalled
        do_reset(); got.delete(); sout_ready = 1'b0;
        din = '{8'h21, 8'h22, 8'h23}; vin = 3'b111;
        step(); step(); step();
        vin = '0;
        @(negedge clk);
        chk("t5_loaded", {sout_valid, p3r, p2r, p1r}, {1'b1, 3'b000});
        #2; rst = 1'b1; #1;
        chk("t5_rst_out", {sout_valid, entry_id, sout_data}, 0);
        chk("t5_rst_ready", {p3r, p2r, p1r}, 0);
        step(); step();
        rst = 1'b0; sout_ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("t5_ready", {p3r, p2r, p1r}, 3'b111);
        chk("t5_no_stale", got.size(), 0);

        // burst on all ports with random backpressure
        do_reset(); got.delete(); n_push = 0; n_got = 0;
        vin = 3'b111;
        for (int c = 0; c < 200; c++) begin
            for (int p = 0; p < 3; p++)
                din[p] = (c % 4 == 0) ? 8'hFF : 8'(p * 64 + c % 64);
            sout_ready = 1'($urandom_range(0, 1));
            step();
        end
        vin = '0; sout_ready = 1'b1;
        repeat (12) step();
        chk("t6_no_loss", n_got, n_push);
        chk("t6_drained", sout_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
